// File: rtl/sigmoid_pkg.sv
// Shared constants for the piecewise-linear activation units: mode encoding,
// region encoding, breakpoints and segment intercepts, plus small helpers that
// scale them to a given fixed-point format.
package sigmoid_pkg;

    typedef enum logic {
        MODE_SIGMOID = 1'b0,
        MODE_RELU    = 1'b1
    } mode_e;

    // Region of |x| relative to the breakpoints 1.0, 2.375 and 5.0.
    typedef enum logic [1:0] {
        REG_LO  = 2'd0,   // |x| < 1
        REG_MID = 2'd1,   // 1 <= |x| < 2.375
        REG_HI  = 2'd2,   // 2.375 <= |x| < 5
        REG_SAT = 2'd3    // |x| >= 5
    } region_e;

    // Breakpoints in eighths: 1.0, 2.375, 5.0.
    localparam int BP_ONE_X8 = 8;
    localparam int BP_MID_X8 = 19;
    localparam int BP_SAT_X8 = 40;

    // Segment intercepts in 32nds: 0.5, 0.625, 0.84375.
    localparam int ICPT_LO_X32  = 16;
    localparam int ICPT_MID_X32 = 20;
    localparam int ICPT_HI_X32  = 27;

    // Fractional bits of the internal result. IN_FRAC+5 keeps a/32 exact; it is
    // widened when the output has more fraction bits, so rounding always has
    // at least one guard bit (narrow inputs are effectively zero-padded).
    function automatic int calc_frac(input int in_frac, input int out_w);
        if (in_frac + 5 > out_w) return in_frac + 5;
        return out_w + 1;
    endfunction

    // Breakpoint given in eighths, expressed with in_frac fractional bits.
    function automatic longint bp_scaled(input int bp_x8, input int in_frac);
        return (longint'(bp_x8) << in_frac) >>> 3;
    endfunction

endpackage

// File: rtl/sigmoid_pwl_core.sv
// Combinational body of the activation: selects the segment for the region of
// |x| and forms the unsigned result with shifts and adds only. Output has F2
// fractional bits; 1.0 is exactly representable. Negative-x mirroring for the
// sigmoid is done by the caller.
module sigmoid_pwl_core
    import sigmoid_pkg::*;
#(
    parameter int IN_FRAC = 12,
    parameter int F2      = IN_FRAC + 5
) (
    input  mode_e              mode,
    input  logic               sign,
    input  region_e            region,
    input  logic [IN_FRAC+2:0] a,      // |x|, only meaningful below 5.0
    output logic [F2+1:0]      y
);

    localparam int Y_W = F2 + 2;
    localparam int EXT = F2 - IN_FRAC - 5;

    localparam logic [Y_W-1:0] ONE       = Y_W'(1) << F2;
    localparam logic [Y_W-1:0] ICPT_LO   = Y_W'(ICPT_LO_X32) << (F2 - 5);
    localparam logic [Y_W-1:0] ICPT_MID  = Y_W'(ICPT_MID_X32) << (F2 - 5);
    localparam logic [Y_W-1:0] ICPT_HI   = Y_W'(ICPT_HI_X32) << (F2 - 5);

    logic [Y_W-1:0] a_y;

    // Segment select and slope/intercept evaluation for both modes.
    always_comb begin
        a_y = Y_W'(a);
        y   = '0;
        if (mode == MODE_RELU) begin
            if (sign)                  y = '0;
            else if (region == REG_LO) y = a_y << (5 + EXT);
            else                       y = ONE;
        end else begin
            case (region)
                REG_LO:  y = (a_y << (3 + EXT)) + ICPT_LO;
                REG_MID: y = (a_y << (2 + EXT)) + ICPT_MID;
                REG_HI:  y = (a_y << EXT) + ICPT_HI;
                default: y = ONE;
            endcase
        end
    end

endmodule

// File: rtl/sigmoid_pwl_pipe.sv
// Three-stage activation pipeline: S1 takes |x| and classifies it, S2 runs the
// PLAN/ReLU core, S3 mirrors negative sigmoid results, rounds half-up and
// clamps into the output register.
//
// Handshake: a sample moves on valid && ready at either port. The only stall
// source is out_valid && !out_ready; while stalled every stage (data and
// valid) holds, in_ready is low, and out_* stay stable. Bubbles travel
// through as invalid stages and are never squeezed out.
module sigmoid_pwl_pipe
    import sigmoid_pkg::*;
#(
    parameter int IN_W    = 22,
    parameter int IN_FRAC = 12,
    parameter int OUT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sign,
    output logic             out_sat
);

    localparam int A_W = IN_W + 1;
    localparam int F2  = calc_frac(IN_FRAC, OUT_W);
    localparam int Y_W = F2 + 2;
    localparam int RSH = F2 - OUT_W;

    localparam logic [A_W-1:0] BP_ONE = A_W'(bp_scaled(BP_ONE_X8, IN_FRAC));
    localparam logic [A_W-1:0] BP_MID = A_W'(bp_scaled(BP_MID_X8, IN_FRAC));
    localparam logic [A_W-1:0] BP_SAT = A_W'(bp_scaled(BP_SAT_X8, IN_FRAC));

    localparam logic [Y_W:0] ONE_F = (Y_W + 1)'(1) << F2;
    localparam logic [Y_W:0] HALF  = (Y_W + 1)'(1) << (RSH - 1);
    localparam logic [Y_W:0] MAXV  = (Y_W + 1)'((1 << OUT_W) - 1);

    logic stall;

    // S1 inputs
    logic               in_sign;
    logic [A_W-1:0]     in_abs;
    region_e            in_region;

    // S1 registers
    logic               v1;
    mode_e              mode1;
    logic               sign1;
    logic [IN_FRAC+2:0] a1;
    region_e            region1;

    // S2 registers
    logic               v2;
    mode_e              mode2;
    logic               sign2;
    logic               sat2;
    logic [Y_W-1:0]     y2;

    logic [Y_W-1:0]     y_core;
    logic               sat_core;
    logic [Y_W:0]       y_flip;
    logic [Y_W:0]       y_rnd;
    logic [OUT_W-1:0]   data_next;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Magnitude in one extra bit so the most negative input negates exactly.
    always_comb begin
        in_sign = in_data[IN_W-1];
        in_abs  = in_sign ? (~{1'b1, in_data} + A_W'(1)) : {1'b0, in_data};
        if (in_abs >= BP_SAT)      in_region = REG_SAT;
        else if (in_abs >= BP_MID) in_region = REG_HI;
        else if (in_abs >= BP_ONE) in_region = REG_MID;
        else                       in_region = REG_LO;
    end

    // S1: capture mode, sign, |x| (low bits suffice below 5.0) and region.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1      <= 1'b0;
            mode1   <= MODE_SIGMOID;
            sign1   <= 1'b0;
            a1      <= '0;
            region1 <= REG_LO;
        end else if (!stall) begin
            v1      <= in_valid;
            mode1   <= mode_e'(in_mode);
            sign1   <= in_sign;
            a1      <= in_abs[IN_FRAC+2:0];
            region1 <= in_region;
        end
    end

    sigmoid_pwl_core #(
        .IN_FRAC (IN_FRAC),
        .F2      (F2)
    ) u_core (
        .mode   (mode1),
        .sign   (sign1),
        .region (region1),
        .a      (a1),
        .y      (y_core)
    );

    // Saturation: sigmoid flat region, or ReLU at/above 1.0.
    always_comb begin
        if (mode1 == MODE_RELU) sat_core = !sign1 && (region1 != REG_LO);
        else                    sat_core = (region1 == REG_SAT);
    end

    // S2: hold the exact unrounded segment value.
    always_ff @(posedge clk) begin
        if (reset) begin
            v2    <= 1'b0;
            mode2 <= MODE_SIGMOID;
            sign2 <= 1'b0;
            sat2  <= 1'b0;
            y2    <= '0;
        end else if (!stall) begin
            v2    <= v1;
            mode2 <= mode1;
            sign2 <= sign1;
            sat2  <= sat_core;
            y2    <= y_core;
        end
    end

    // Mirror negative sigmoid results before rounding, then round half-up and clamp.
    always_comb begin
        if (mode2 == MODE_SIGMOID && sign2) y_flip = ONE_F - {1'b0, y2};
        else                                y_flip = {1'b0, y2};
        y_rnd = (y_flip + HALF) >> RSH;
        if (y_rnd > MAXV) data_next = '1;
        else              data_next = y_rnd[OUT_W-1:0];
    end

    // S3: output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sign  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            out_valid <= v2;
            out_data  <= data_next;
            out_sign  <= sign2;
            out_sat   <= sat2;
        end
    end

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// Bench for sigmoid_pwl_pipe: directed vector table, handshake streaming with
// random backpressure, mid-flight reset, and a sweep against a real-valued model.
module tb_sigmoid_pwl_pipe;

    localparam int IN_W    = 22;
    localparam int IN_FRAC = 12;
    localparam int OUT_W   = 8;
    localparam int EW      = OUT_W + 2;   // {data, sign, sat}
    localparam int N_VEC   = 20;

    typedef struct {
        int               x;
        logic             mode;
        logic [OUT_W-1:0] data;
        logic             sign;
        logic             sat;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid = 1'b0;
    logic             in_mode = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_sign;
    logic             out_sat;

    logic rand_ready = 1'b0;
    logic ready_level = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [EW-1:0] exp_q[$];
    int            x_q[$];
    vec_t          vecs[N_VEC];

    sigmoid_pwl_pipe #(
        .IN_W    (IN_W),
        .IN_FRAC (IN_FRAC),
        .OUT_W   (OUT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sign  (out_sign),
        .out_sat   (out_sat)
    );

    // downstream ready, changed only just after the rising edge
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // reference model in real arithmetic
    function automatic logic [EW-1:0] model(input int x, input logic m);
        real  a, y;
        int   q;
        logic s, sat;
        s   = (x < 0);
        a   = real'(s ? -x : x) / 4096.0;
        sat = 1'b0;
        if (m == 1'b0) begin
            if (a >= 5.0) begin
                y = 1.0;
                sat = 1'b1;
            end else if (a >= 2.375) y = a / 32.0 + 0.84375;
            else if (a >= 1.0)       y = a / 8.0 + 0.625;
            else                     y = a / 4.0 + 0.5;
            if (s) y = 1.0 - y;
        end else begin
            if (s) y = 0.0;
            else if (a >= 1.0) begin
                y = 1.0;
                sat = 1'b1;
            end else y = a;
        end
        q = int'($floor(y * 256.0 + 0.5));
        if (q > 255) q = 255;
        if (q < 0) q = 0;
        return {q[OUT_W-1:0], s, sat};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int x, input logic m, input logic [OUT_W-1:0] d,
                           input logic s, input logic sat);
        vecs[i] = '{x, m, d, s, sat};
    endtask

    // driver: call just after a rising edge; returns just after the accepting edge
    task automatic send(input int x, input logic m, input logic [EW-1:0] exp);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = x[IN_W-1:0];
        in_mode  = m;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        if (acc) begin
            exp_q.push_back(exp);
            x_q.push_back(x);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: x=%0d never accepted", x);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(posedge clk);
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // scoreboard / protocol monitor, sampled on the falling edge
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_word = '0;
    always @(negedge clk) begin
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        int            xv;
        act = {out_data, out_sign, out_sat};
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready));
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || act !== prev_word) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b %h expected v=1 %h", out_valid, act, prev_word);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got %h with nothing expected", act);
                end else begin
                    exp = exp_q.pop_front();
                    xv  = x_q.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL out x=%0d: got data=%h sign=%b sat=%b expected data=%h sign=%b sat=%b",
                                 xv, act[EW-1:2], act[1], act[0], exp[EW-1:2], exp[1], exp[0]);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = act;
        end
    end

    initial begin
        int n;
        int stale;
        int rx;
        logic rm;

        // directed table: sigmoid points, breakpoints, extremes, ReLU
        set_vec(0,  0,        1'b0, 8'h80, 1'b0, 1'b0);
        set_vec(1,  2048,     1'b0, 8'hA0, 1'b0, 1'b0);
        set_vec(2,  4096,     1'b0, 8'hC0, 1'b0, 1'b0);
        set_vec(3,  -4096,    1'b0, 8'h40, 1'b1, 1'b0);
        set_vec(4,  -2048,    1'b0, 8'h60, 1'b1, 1'b0);
        set_vec(5,  9728,     1'b0, 8'hEB, 1'b0, 1'b0);
        set_vec(6,  9727,     1'b0, 8'hEC, 1'b0, 1'b0);
        set_vec(7,  -9728,    1'b0, 8'h15, 1'b1, 1'b0);
        set_vec(8,  20480,    1'b0, 8'hFF, 1'b0, 1'b1);
        set_vec(9,  -20480,   1'b0, 8'h00, 1'b1, 1'b1);
        set_vec(10, -20479,   1'b0, 8'h00, 1'b1, 1'b0);
        set_vec(11, -2097152, 1'b0, 8'h00, 1'b1, 1'b1);
        set_vec(12, 2097151,  1'b0, 8'hFF, 1'b0, 1'b1);
        set_vec(13, -100,     1'b1, 8'h00, 1'b1, 1'b0);
        set_vec(14, 2048,     1'b1, 8'h80, 1'b0, 1'b0);
        set_vec(15, 4095,     1'b1, 8'hFF, 1'b0, 1'b0);
        set_vec(16, 4096,     1'b1, 8'hFF, 1'b0, 1'b1);
        set_vec(17, 0,        1'b1, 8'h00, 1'b0, 1'b0);
        set_vec(18, 8,        1'b1, 8'h01, 1'b0, 1'b0);
        set_vec(19, 7,        1'b1, 8'h00, 1'b0, 1'b0);

        // reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sign", out_sign, 0);
        chk("rst_out_sat", out_sat, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // unstalled latency
        ready_level = 1'b1;
        @(posedge clk);
        #1;
        send(4096, 1'b0, model(4096, 1'b0));
        n = 1;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
        chk("latency", n, 3);
        wait_drain();

        // directed vectors, back to back
        for (int i = 0; i < N_VEC; i++)
            send(vecs[i].x, vecs[i].mode, {vecs[i].data, vecs[i].sign, vecs[i].sat});
        wait_drain();

        // streaming with random backpressure and mixed modes
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx = int'($urandom_range(0, 60000)) - 30000;
            rm = 1'($urandom_range(0, 1));
            send(rx, rm, model(rx, rm));
        end
        wait_drain();
        rand_ready = 1'b0;
        ready_level = 1'b1;

        // reset with three samples in flight
        ready_level = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(1000, 1'b0, model(1000, 1'b0));
        send(-3000, 1'b1, model(-3000, 1'b1));
        send(12000, 1'b0, model(12000, 1'b0));
        chk("stalled_before_reset", out_valid, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_flush", out_valid, 0);
        exp_q.delete();
        x_q.delete();
        reset = 1'b0;
        ready_level = 1'b1;
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no_stale", stale, 0);
        @(posedge clk);
        #1;

        // sweep both modes against the model
        for (int x = -16640; x <= 16640; x += 32) begin
            send(x, 1'b0, model(x, 1'b0));
            send(x, 1'b1, model(x, 1'b1));
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
